// File: rtl/tetris_move_sequencer.sv
// Game-flow controller: arbitrates gravity/button moves onto the collision checker and sequences
// spawn, lock, line clear and game over. Optional gravity speed-up under LEVEL_SPEEDUP_EN.
module tetris_move_sequencer #(
    parameter int unsigned GRAVITY_TICKS = 25000,
    parameter int unsigned GRAVITY_MIN   = 3125,
    parameter int unsigned CNT_W         = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_rot,
    input  logic       btn_drop,
    output logic       chk_req,
    output logic [2:0] chk_op,
    input  logic       chk_ack,
    input  logic       chk_ok,
    output logic       commit,
    output logic       spawn,
    output logic       lock,
    output logic       clr_req,
    input  logic       clr_done,
    output logic       playing,
    output logic       game_over,
    output logic [7:0] lock_count
);

    typedef enum logic [3:0] {
        st_idle,
        st_spawn,
        st_spawn_chk,
        st_ready,
        st_check,
        st_commit,
        st_lock,
        st_clear,
        st_over
    } state_e;

    localparam logic [2:0] OP_DOWN  = 3'd0;
    localparam logic [2:0] OP_LEFT  = 3'd1;
    localparam logic [2:0] OP_RIGHT = 3'd2;
    localparam logic [2:0] OP_ROT   = 3'd3;
    localparam logic [2:0] OP_SPAWN = 3'd4;

    // The starting interval is never allowed below the floor.
    localparam int unsigned BASE_TICKS = (GRAVITY_TICKS < GRAVITY_MIN) ? GRAVITY_MIN
                                                                       : GRAVITY_TICKS;
    localparam logic [CNT_W-1:0] TICKS_INIT = CNT_W'(BASE_TICKS);

    // Button bit order: 0 left, 1 right, 2 rotate, 3 drop.
    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_ROT   = 2;
    localparam int BTN_DROP  = 3;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic             drop_mode_q, drop_mode_d;
    logic [7:0]       lock_count_q, lock_count_d;

    logic [3:0]       btn_raw;
    logic [3:0]       sync1_q, sync2_q, prev_q;
    logic [3:0]       btn_edge;
    logic [3:0]       pend_q;
    logic [3:0]       btn_issue;
    logic             grav_pend_q;
    logic             grav_issue;
    logic             grav_expire;
    logic             accept_edges;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] grav_interval;

    assign btn_raw    = {btn_drop, btn_rot, btn_right, btn_left};
    assign btn_edge   = sync2_q & ~prev_q;
    assign lock_count = lock_count_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

`ifdef LEVEL_SPEEDUP_EN
    localparam logic [CNT_W-1:0] TICKS_MIN = CNT_W'(GRAVITY_MIN);

    logic [CNT_W-1:0] interval_q, interval_d;
    logic [CNT_W-1:0] interval_half;

    assign interval_half = interval_q >> 1;
    assign grav_interval = interval_q;

    // Halve on every eighth lock of the game, never below the floor.
    always_comb begin
        interval_d = interval_q;
        if ((state_q == st_idle || state_q == st_over) && start) begin
            interval_d = TICKS_INIT;
        end else if (state_q == st_lock && lock_count_d[2:0] == 3'd0) begin
            interval_d = (interval_half < TICKS_MIN) ? TICKS_MIN : interval_half;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            interval_q <= TICKS_INIT;
        end else begin
            interval_q <= interval_d;
        end
    end
`else
    assign grav_interval = TICKS_INIT;
`endif

    assign accept_edges = playing & ~drop_mode_q;
    assign grav_expire  = playing & (cnt_q <= CNT_W'(1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q       <= TICKS_INIT;
            pend_q      <= '0;
            grav_pend_q <= 1'b0;
        end else if (state_q == st_spawn) begin
            cnt_q       <= grav_interval;
            pend_q      <= '0;
            grav_pend_q <= 1'b0;
        end else begin
            if (grav_expire) begin
                cnt_q <= grav_interval;
            end else if (playing) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            // An edge landing on an already-pending (or just-issued) bit is dropped.
            pend_q      <= (pend_q | (btn_edge & {4{accept_edges}})) & ~btn_issue;
            grav_pend_q <= (grav_pend_q | (grav_expire & ~drop_mode_q)) & ~grav_issue;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= st_idle;
            op_q         <= OP_DOWN;
            drop_mode_q  <= 1'b0;
            lock_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            drop_mode_q  <= drop_mode_d;
            lock_count_q <= lock_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        drop_mode_d  = drop_mode_q;
        lock_count_d = lock_count_q;
        btn_issue    = 4'b0000;
        grav_issue   = 1'b0;
        chk_req      = 1'b0;
        chk_op       = OP_DOWN;
        commit       = 1'b0;
        spawn        = 1'b0;
        lock         = 1'b0;
        clr_req      = 1'b0;
        playing      = 1'b1;
        game_over    = 1'b0;

        unique case (state_q)
            st_idle: begin
                playing = 1'b0;
                if (start) begin
                    state_d = st_spawn;
                end
            end
            st_spawn: begin
                spawn   = 1'b1;
                state_d = st_spawn_chk;
            end
            st_spawn_chk: begin
                chk_req = 1'b1;
                chk_op  = OP_SPAWN;
                if (chk_ack) begin
                    state_d = chk_ok ? st_ready : st_over;
                end
            end
            st_ready: begin
                if (grav_pend_q) begin
                    op_d       = OP_DOWN;
                    grav_issue = 1'b1;
                    state_d    = st_check;
                end else if (pend_q[BTN_DROP]) begin
                    op_d                = OP_DOWN;
                    drop_mode_d         = 1'b1;
                    btn_issue[BTN_DROP] = 1'b1;
                    state_d             = st_check;
                end else if (pend_q[BTN_ROT]) begin
                    op_d               = OP_ROT;
                    btn_issue[BTN_ROT] = 1'b1;
                    state_d            = st_check;
                end else if (pend_q[BTN_LEFT]) begin
                    op_d                = OP_LEFT;
                    btn_issue[BTN_LEFT] = 1'b1;
                    state_d             = st_check;
                end else if (pend_q[BTN_RIGHT]) begin
                    op_d                 = OP_RIGHT;
                    btn_issue[BTN_RIGHT] = 1'b1;
                    state_d              = st_check;
                end
            end
            st_check: begin
                chk_req = 1'b1;
                chk_op  = op_q;
                if (chk_ack) begin
                    if (chk_ok) begin
                        state_d = st_commit;
                    end else if (op_q == OP_DOWN) begin
                        state_d     = st_lock;
                        drop_mode_d = 1'b0;
                    end else begin
                        state_d = st_ready;
                    end
                end
            end
            st_commit: begin
                commit = 1'b1;
                // Drop mode keeps stepping down until a down check fails.
                state_d = drop_mode_q ? st_check : st_ready;
            end
            st_lock: begin
                lock         = 1'b1;
                lock_count_d = lock_count_q + 8'd1;
                state_d      = st_clear;
            end
            st_clear: begin
                clr_req = 1'b1;
                if (clr_done) begin
                    state_d = st_spawn;
                end
            end
            st_over: begin
                playing   = 1'b0;
                game_over = 1'b1;
                if (start) begin
                    lock_count_d = 8'd0;
                    state_d      = st_spawn;
                end
            end
            default: begin
                playing = 1'b0;
                state_d = st_idle;
            end
        endcase
    end

endmodule

// File: tb/tb_tetris_move_sequencer.sv
// Scoreboard bench for tetris_move_sequencer: directed stimulus queues expected events,
// a monitor pops and compares them, a responder answers checker requests.
module tb_tetris_move_sequencer;

    localparam int unsigned TICKS = 64;
    localparam int EV_COMMIT = 8;
    localparam int EV_LOCK   = 9;
    localparam int EV_SPAWN  = 10;
    localparam int EV_CLR    = 11;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       btn_left = 1'b0, btn_right = 1'b0, btn_rot = 1'b0, btn_drop = 1'b0;
    logic       chk_req;
    logic [2:0] chk_op;
    logic       chk_ack = 1'b0;
    logic       chk_ok = 1'b0;
    logic       commit, spawn, lock, clr_req;
    logic       clr_done = 1'b0;
    logic       playing, game_over;
    logic [7:0] lock_count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int spawn_cyc = 0;
    int hs_cyc = 0;
    int prev_hs = -100;
    int exp_q[$];
    bit ok_q[$];
    bit hold_ack = 1'b0;

    tetris_move_sequencer #(
        .GRAVITY_TICKS(TICKS),
        .GRAVITY_MIN  (8),
        .CNT_W        (16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_rot   (btn_rot),
        .btn_drop  (btn_drop),
        .chk_req   (chk_req),
        .chk_op    (chk_op),
        .chk_ack   (chk_ack),
        .chk_ok    (chk_ok),
        .commit    (commit),
        .spawn     (spawn),
        .lock      (lock),
        .clr_req   (clr_req),
        .clr_done  (clr_done),
        .playing   (playing),
        .game_over (game_over),
        .lock_count(lock_count)
    );

    initial forever #5 clock = ~clock;

    function automatic string ev_name(int e);
        case (e)
            EV_COMMIT: return "commit";
            EV_LOCK:   return "lock";
            EV_SPAWN:  return "spawn";
            EV_CLR:    return "clear-done";
            default:   return $sformatf("req-op%0d", e);
        endcase
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d events outstanding after %0d cycles, expected 0",
                     name, exp_q.size(), budget);
            exp_q.delete();
            ok_q.delete();
        end
    endtask

    // Monitor: one observable event per cycle, compared against the expected queue.
    initial forever begin
        int got;
        int want;
        @(negedge clock);
        cyc++;
        if (!reset) begin
            got = -1;
            if (spawn) begin
                got = EV_SPAWN;
                spawn_cyc = cyc;
            end else if (chk_req && chk_ack) begin
                got = int'(chk_op);
                checks++;
                if (cyc - prev_hs < 2) begin
                    errors++;
                    $display("FAIL handshake gap: got %0d cycles, expected at least 2",
                             cyc - prev_hs);
                end
                prev_hs = cyc;
                hs_cyc = cyc;
            end else if (commit) begin
                got = EV_COMMIT;
            end else if (lock) begin
                got = EV_LOCK;
            end else if (clr_req && clr_done) begin
                got = EV_CLR;
            end
            if (got >= 0) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: got %s, expected no event", ev_name(got));
                end else begin
                    want = exp_q.pop_front();
                    if (got != want) begin
                        errors++;
                        $display("FAIL scoreboard: got %s, expected %s",
                                 ev_name(got), ev_name(want));
                    end
                end
            end
        end
    end

    // Checker model: acks the first cycle a request is visible, with the queued verdict.
    initial forever begin
        @(posedge clock);
        #1;
        if (chk_ack) begin
            chk_ack = 1'b0;
        end else if (chk_req && !hold_ack && !reset) begin
            if (ok_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL responder: got request op%0d, expected no request", chk_op);
                chk_ok = 1'b1;
            end else begin
                chk_ok = ok_q.pop_front();
            end
            chk_ack = 1'b1;
        end
    end

    initial begin
        int n;
        tick(2);
        check("reset chk_req", chk_req, 0);
        check("reset playing", playing, 0);
        check("reset game_over", game_over, 0);
        check("reset lock_count", lock_count, 0);
        check("reset spawn", spawn, 0);
        reset = 1'b0;
        tick(2);

        // Start, spawn fits, first gravity step.
        exp_q = '{EV_SPAWN, 4, 0, EV_COMMIT};
        ok_q = '{1'b1, 1'b1};
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        check("playing after start", playing, 1);
        wait_drain("start/gravity", TICKS + 30);
        check("gravity request delay in window",
              int'((hs_cyc - spawn_cyc >= TICKS) && (hs_cyc - spawn_cyc <= TICKS + 3)), 1);
        tick(3);

        // Rotate beats left; a held button produces no repeat.
        exp_q = '{3, EV_COMMIT, 1, EV_COMMIT};
        ok_q = '{1'b1, 1'b1};
        btn_left = 1'b1;
        btn_rot = 1'b1;
        wait_drain("priority", 30);
        tick(10);
        btn_left = 1'b0;
        btn_rot = 1'b0;
        tick(4);

        // Illegal right move: discarded, no commit, no lock.
        exp_q = '{2};
        ok_q = '{1'b0};
        btn_right = 1'b1;
        tick(4);
        btn_right = 1'b0;
        wait_drain("illegal move", 30);
        tick(6);
        check("illegal lock_count", lock_count, 0);
        check("illegal playing", playing, 1);

        // Hard drop on a fresh game.
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);
        exp_q = '{EV_SPAWN, 4};
        ok_q = '{1'b1};
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_drain("respawn", 20);
        exp_q = '{0, EV_COMMIT, 0, EV_COMMIT, 0, EV_COMMIT, 0, EV_LOCK};
        ok_q = '{1'b1, 1'b1, 1'b1, 1'b0};
        btn_drop = 1'b1;
        tick(2);
        btn_drop = 1'b0;
        wait_drain("hard drop", 40);
        check("drop lock_count", lock_count, 1);
        check("clr_req asserted", clr_req, 1);
        tick(3);
        check("clr_req held", clr_req, 1);

        // Clear completes; next spawn does not fit.
        exp_q = '{EV_CLR, EV_SPAWN, 4};
        ok_q = '{1'b0};
        clr_done = 1'b1;
        tick(1);
        clr_done = 1'b0;
        wait_drain("clear/spawn", 20);
        tick(2);
        check("over game_over", game_over, 1);
        check("over playing", playing, 0);
        check("over lock_count", lock_count, 1);

        // Restart from game over.
        exp_q = '{EV_SPAWN, 4};
        ok_q = '{1'b1};
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_drain("restart", 20);
        check("restart lock_count", lock_count, 0);
        check("restart playing", playing, 1);
        check("restart game_over", game_over, 0);

        // Reset in the middle of a checker handshake.
        hold_ack = 1'b1;
        btn_right = 1'b1;
        n = 0;
        while (!chk_req && n < 20) begin
            tick(1);
            n++;
        end
        check("request before reset", chk_req, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async reset chk_req", chk_req, 0);
        check("async reset commit", commit, 0);
        check("async reset game_over", game_over, 0);
        check("async reset playing", playing, 0);
        btn_right = 1'b0;
        @(posedge clock);
        #1;
        tick(2);
        reset = 1'b0;
        hold_ack = 1'b0;
        tick(3);
        check("idle after reset playing", playing, 0);
        check("idle after reset chk_req", chk_req, 0);
        check("idle after reset lock_count", lock_count, 0);
        tick(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
